// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle CPU sequencer with hold, retire counter and sticky illegal-opcode trap
module multicycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    input  logic        hold,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic        PCSource,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUop,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic [15:0] instret,
    output logic        illegal
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        EXEC_I    = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        TRAP      = 4'd10
    } state_t;
    state_t      state_q, state_d;
    logic [15:0] instret_q, instret_d;
    logic        illegal_q, illegal_d;
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        PCSource    = 1'b0;
        ALUSrcB     = 2'b00;
        ALUop       = 2'b00;
        instr_done  = 1'b0;
        state_d     = state_q;
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                state_d = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                state_d = (opcode == 7'b0110011) ? EXEC_R :
                          (opcode == 7'b0010011) ? EXEC_I :
                          (opcode == 7'b0000011 || opcode == 7'b0100011) ? MEM_ADDR :
                          (opcode == 7'b1100011) ? BRANCH : TRAP;
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == 7'b0000011) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = mem_ready ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEM_WRITE: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                state_d    = mem_ready ? FETCH : MEM_WRITE;
            end
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUop   = 2'b10;
                state_d = ALU_WB;
            end
            EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUop   = 2'b10;
                state_d = ALU_WB;
            end
            ALU_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUop       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
                instr_done  = 1'b1;
                state_d     = FETCH;
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
        if (hold) state_d = state_q;
        // hold and reset silence every enable; mux selects stay as decoded
        if (hold || !rst_n) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            instr_done  = 1'b0;
        end
        instret_d = instret_q + {15'd0, instr_done};
        illegal_d = illegal_q | (state_d == TRAP);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            instret_q <= 16'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end
    assign state   = state_q;
    assign instret = instret_q;
    assign illegal = illegal_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: vector table, corner-case sequences and random run against an instruction-route model
module tb_multicycle_control;
    logic        clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0, hold = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, ALUSrcA, PCSource;
    logic [1:0]  ALUSrcB, ALUop;
    logic [3:0]  state;
    logic        instr_done, illegal;
    logic [15:0] instret;
    logic [14:0] dword;
    int n_cmp = 0, n_bad = 0;
    int m_idx = 0, m_cnt = 0;
    bit m_ill = 1'b0;
    localparam int PCW = 1 << 14, PCC = 1 << 13, IORD = 1 << 12, MRD = 1 << 11, MWR = 1 << 10;
    localparam int IRW = 1 << 9, M2R = 1 << 8, RGW = 1 << 7, ASA = 1 << 6, PCS = 1 << 5;
    localparam int B1 = 1 << 3, B2 = 2 << 3, B3 = 3 << 3, AOP1 = 1 << 1, AOP2 = 2 << 1, DONE = 1;
    localparam int EN = PCW | PCC | MRD | MWR | IRW | RGW | DONE;
    typedef struct {
        bit         r;
        logic [6:0] op;
        bit         mr;
        bit         h;
        int         st;
        int         word;
        int         ir;
    } vec_t;
    vec_t tv[$];
    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .hold(hold),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
        .state(state), .instr_done(instr_done), .instret(instret), .illegal(illegal)
    );
    assign dword = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                    RegWrite, ALUSrcA, PCSource, ALUSrcB, ALUop, instr_done};
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask
    task automatic apply(input bit r, input logic [6:0] op, input bit mr, input bit h);
        @(negedge clk);
        rst_n = r;
        opcode = op;
        mem_ready = mr;
        hold = h;
        #1;
    endtask
    task automatic addv(input bit r, input logic [6:0] op, input bit mr, input bit h,
                        input int st, input int w, input int ir);
        vec_t v;
        v.r = r; v.op = op; v.mr = mr; v.h = h; v.st = st; v.word = w; v.ir = ir;
        tv.push_back(v);
    endtask
    // Expected control word for a state code, straight from the per-state output table
    function automatic int exp_word(int s, bit mr, bit h, bit r);
        int w;
        case (s)
            0:       w = MRD | B1 | (mr ? (IRW | PCW) : 0);
            1:       w = B3;
            2:       w = ASA | B2;
            3:       w = MRD | IORD;
            4:       w = RGW | M2R | DONE;
            5:       w = MWR | IORD | (mr ? DONE : 0);
            6:       w = ASA | AOP2;
            7:       w = ASA | B2 | AOP2;
            8:       w = RGW | DONE;
            9:       w = ASA | AOP1 | PCC | PCS | DONE;
            default: w = 0;
        endcase
        if (h || !r) w &= ~EN;
        return w;
    endfunction
    // Each instruction class is a fixed route of state codes; the last step retires it
    function automatic int route_len(logic [6:0] op);
        case (op)
            7'h33, 7'h13, 7'h23: return 4;
            7'h03:               return 5;
            default:             return 3;
        endcase
    endfunction
    function automatic int route_at(logic [6:0] op, int i);
        int r[5];
        r = '{0, 1, 10, 10, 10};
        case (op)
            7'h33:   r = '{0, 1, 6, 8, 0};
            7'h13:   r = '{0, 1, 7, 8, 0};
            7'h03:   r = '{0, 1, 2, 3, 4};
            7'h23:   r = '{0, 1, 2, 5, 0};
            7'h63:   r = '{0, 1, 9, 0, 0};
            default: ;
        endcase
        return r[i];
    endfunction
    task automatic model_step();
        int s;
        s = route_at(opcode, m_idx);
        if (!rst_n) begin
            m_idx = 0; m_cnt = 0; m_ill = 1'b0;
        end else if (hold || s == 10 || ((s == 0 || s == 3 || s == 5) && !mem_ready)) begin
        end else if (m_idx == route_len(opcode) - 1) begin
            m_idx = 0;
            m_cnt = (m_cnt + 1) & 16'hFFFF;
        end else begin
            m_idx++;
            if (route_at(opcode, m_idx) == 10) m_ill = 1'b1;
        end
    endtask
    initial begin
        logic [6:0] legal[5];
        int ld_st[8], ld_mr[8];
        legal = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
        addv(1, 7'h33, 1, 0, 0, MRD | B1 | IRW | PCW, 0);
        addv(1, 7'h33, 1, 0, 1, B3, 0);
        addv(1, 7'h33, 1, 0, 6, ASA | AOP2, 0);
        addv(1, 7'h33, 1, 0, 8, RGW | DONE, 0);
        addv(1, 7'h63, 1, 1, 0, B1, 1);
        addv(1, 7'h63, 1, 1, 0, B1, 1);
        addv(1, 7'h63, 1, 0, 0, MRD | B1 | IRW | PCW, 1);
        addv(1, 7'h63, 1, 0, 1, B3, 1);
        addv(1, 7'h63, 1, 0, 9, ASA | AOP1 | PCC | PCS | DONE, 1);
        addv(1, 7'h13, 1, 0, 0, MRD | B1 | IRW | PCW, 2);
        addv(1, 7'h13, 1, 0, 1, B3, 2);
        addv(1, 7'h13, 1, 0, 7, ASA | B2 | AOP2, 2);
        addv(1, 7'h13, 1, 1, 8, 0, 2);
        addv(1, 7'h13, 1, 0, 8, RGW | DONE, 2);
        addv(1, 7'h23, 0, 0, 0, MRD | B1, 3);
        addv(1, 7'h23, 1, 0, 0, MRD | B1 | IRW | PCW, 3);
        addv(1, 7'h23, 1, 0, 1, B3, 3);
        addv(1, 7'h23, 1, 0, 2, ASA | B2, 3);
        addv(1, 7'h23, 1, 0, 5, MWR | IORD | DONE, 3);
        addv(1, 7'h23, 1, 0, 0, MRD | B1 | IRW | PCW, 4);
        apply(0, 7'h33, 1, 1);
        chk("rst_enables", dword & EN, 0);
        for (int i = 0; i < tv.size(); i++) begin
            apply(tv[i].r, tv[i].op, tv[i].mr, tv[i].h);
            chk($sformatf("vec%0d_state", i), state, tv[i].st);
            chk($sformatf("vec%0d_ctrl", i), dword, tv[i].word);
            chk($sformatf("vec%0d_instret", i), instret, tv[i].ir);
        end
        // load with three wait cycles in MEM_READ
        ld_st = '{0, 1, 2, 3, 3, 3, 3, 4};
        ld_mr = '{1, 1, 1, 0, 0, 0, 1, 1};
        apply(0, 7'h03, 1, 0);
        for (int i = 0; i < 8; i++) begin
            apply(1, 7'h03, ld_mr[i][0], 0);
            chk($sformatf("ld_state%0d", i), state, ld_st[i]);
            chk($sformatf("ld_ctrl%0d", i), dword, exp_word(ld_st[i], ld_mr[i][0], 0, 1));
        end
        apply(1, 7'h03, 1, 0);
        chk("ld_done_state", state, 0);
        chk("ld_done_instret", instret, 1);
        // illegal opcode traps until reset
        apply(0, 7'h7F, 1, 0);
        apply(1, 7'h7F, 1, 0);
        apply(1, 7'h7F, 1, 0);
        chk("trap_decode", state, 1);
        for (int i = 0; i < 20; i++) begin
            apply(1, 7'h7F, 1'($urandom), 1'($urandom));
            chk("trap_state", state, 10);
            chk("trap_illegal", illegal, 1);
            chk("trap_ctrl", dword, 0);
        end
        apply(0, 7'h7F, 1, 0);
        chk("trap_rst_en", dword & EN, 0);
        apply(1, 7'h33, 0, 0);
        chk("trap_rst_state", state, 0);
        chk("trap_rst_illegal", illegal, 0);
        // reset in the middle of a stalled store
        apply(0, 7'h23, 1, 0);
        apply(1, 7'h23, 1, 0);
        apply(1, 7'h23, 1, 0);
        apply(1, 7'h23, 0, 0);
        apply(1, 7'h23, 0, 0);
        chk("sd_wait_state", state, 5);
        chk("sd_wait_memwrite", MemWrite, 1);
        apply(0, 7'h23, 0, 0);
        chk("sd_rst_memwrite", MemWrite, 0);
        chk("sd_rst_en", dword & EN, 0);
        apply(1, 7'h23, 0, 0);
        chk("sd_rst_state", state, 0);
        chk("sd_rst_instret", instret, 0);
        // retire counter wrap via beq loop from a preloaded count
        apply(0, 7'h63, 1, 0);
        apply(1, 7'h63, 1, 0);
        dut.instret_q = 16'hFFFE;
        for (int k = 0; k < 2; k++) begin
            apply(1, 7'h63, 1, 0);
            apply(1, 7'h63, 1, 0);
            chk("wrap_branch_state", state, 9);
            apply(1, 7'h63, 1, 0);
            chk($sformatf("wrap_instret%0d", k), instret, (k == 0) ? 32'hFFFF : 32'h0000);
        end
        // random run against the route model
        apply(0, 7'h33, 1, 0);
        model_step();
        for (int c = 0; c < 3000; c++) begin
            logic [6:0] op;
            bit r;
            op = opcode;
            if (m_idx == 0) op = ($urandom_range(0, 24) == 0) ? 7'($urandom) : legal[$urandom_range(0, 4)];
            r = (route_at(opcode, m_idx) == 10) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 99) != 0);
            apply(r, op, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
            chk("rnd_state", state, route_at(opcode, m_idx));
            chk("rnd_ctrl", dword, exp_word(route_at(opcode, m_idx), mem_ready, hold, rst_n));
            chk("rnd_instret", instret, m_cnt);
            chk("rnd_illegal", illegal, m_ill);
            model_step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
